pipe_stage_reg: RTL and testbench

- Parametrised pipeline register for the pipelined ARM datapath; successor to the fixed single-stage writeback register.
- Carries {valid, RegWE, Rd, Data} through DEPTH register stages.
- Adds stall (hold), flush (bubble insertion), valid tracking, an occupancy count and a forwarding lookup across all in-flight stages.
- Instantiated between EX/Mem/WR and wherever an N-cycle delay of a writeback bundle is needed.

---
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 tb/tb_pipe_stage_reg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage writeback-bundle delay line with stall,
// flush, valid tracking, occupancy count and youngest-first forwarding.
// Ports:
//   clk, reset (async, active-high)
//   stall, flush (flush wins over stall)
//   in_valid, RegWE, Rd, DataIn (input bundle; loaded into stage 0)
//   fwd_rd (forwarding lookup index)
//   valid_out, RegWE_out, Rd_out, DataOut (last-stage bundle)
//   fwd_hit, fwd_data (youngest in-flight writer of fwd_rd)
//   occupancy (number of valid stages)
module pipe_stage_reg #(
    parameter int DATA_W   = 64,
    parameter int RD_W     = 5,
    parameter int DEPTH    = 1,
    parameter int ZERO_REG = 31,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              RegWE,
    input  logic [RD_W-1:0]   Rd,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [RD_W-1:0]   fwd_rd,
    output logic              valid_out,
    output logic              RegWE_out,
    output logic [RD_W-1:0]   Rd_out,
    output logic [DATA_W-1:0] DataOut,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_we;
    logic [RD_W-1:0]   r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_occ;

    logic [DEPTH-1:0]  w_match;
    logic              w_fwd_ok;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_we    <= '0;
            r_occ   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k]   <= '0;
                r_data[k] <= '0;
            end
        end else if (flush) begin
            // Bubbles keep their Rd/Data; only the qualifiers drop.
            r_valid <= '0;
            r_we    <= '0;
            r_occ   <= '0;
        end else if (!stall) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_rd[k]    <= r_rd[k-1];
                r_data[k]  <= r_data[k-1];
            end
            r_valid[0] <= in_valid;
            r_we[0]    <= RegWE & in_valid;
            r_rd[0]    <= Rd;
            r_data[0]  <= DataIn;
            // One enters, one may leave; never exceeds DEPTH.
            r_occ <= r_occ + CNT_W'(in_valid)
                           - CNT_W'(r_valid[DEPTH-1]);
        end
    end

    assign w_fwd_ok = (fwd_rd != RD_W'(ZERO_REG));

    always_comb begin
        w_match    = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_match[k] = r_valid[k] & r_we[k]
                       & (r_rd[k] == fwd_rd) & w_fwd_ok;
        end
        // Walk oldest to youngest so the youngest match is written last.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[k];
            end
        end
    end

    assign valid_out = r_valid[DEPTH-1];
    assign RegWE_out = r_valid[DEPTH-1] & r_we[DEPTH-1];
    assign Rd_out    = r_rd[DEPTH-1];
    assign DataOut   = r_data[DEPTH-1];
    assign fwd_hit   = w_fwd_hit;
    assign fwd_data  = w_fwd_data;
    assign occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: DEPTH=1,2,3 instances on shared inputs,
// checked by vector tables, directed sequences and a queue model.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        RegWE;
    logic [4:0]  Rd;
    logic [63:0] DataIn;
    logic [4:0]  fwd_rd;

    logic        vo_a   [3];
    logic        we_a   [3];
    logic [4:0]  rd_a   [3];
    logic [63:0] dat_a  [3];
    logic        hit_a  [3];
    logic [63:0] fdat_a [3];
    logic [3:0]  occ_a  [3];
    logic [0:0]  occ1;
    logic [1:0]  occ2;
    logic [1:0]  occ3;

    assign occ_a[0] = {3'b0, occ1};
    assign occ_a[1] = {2'b0, occ2};
    assign occ_a[2] = {2'b0, occ3};

    pipe_stage_reg #(.DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .RegWE(RegWE), .Rd(Rd), .DataIn(DataIn),
        .fwd_rd(fwd_rd), .valid_out(vo_a[0]), .RegWE_out(we_a[0]),
        .Rd_out(rd_a[0]), .DataOut(dat_a[0]), .fwd_hit(hit_a[0]),
        .fwd_data(fdat_a[0]), .occupancy(occ1)
    );

    pipe_stage_reg #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .RegWE(RegWE), .Rd(Rd), .DataIn(DataIn),
        .fwd_rd(fwd_rd), .valid_out(vo_a[1]), .RegWE_out(we_a[1]),
        .Rd_out(rd_a[1]), .DataOut(dat_a[1]), .fwd_hit(hit_a[1]),
        .fwd_data(fdat_a[1]), .occupancy(occ2)
    );

    pipe_stage_reg #(.DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .RegWE(RegWE), .Rd(Rd), .DataIn(DataIn),
        .fwd_rd(fwd_rd), .valid_out(vo_a[2]), .RegWE_out(we_a[2]),
        .Rd_out(rd_a[2]), .DataOut(dat_a[2]), .fwd_hit(hit_a[2]),
        .fwd_data(fdat_a[2]), .occupancy(occ3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    typedef struct {
        bit          v;
        bit          we;
        logic [4:0]  rd;
        logic [63:0] data;
    } bund_t;

    // mq[d] holds the in-flight bundles of the DEPTH=d+1 instance,
    // youngest at the front, oldest (the output) at the back.
    bund_t mq [3][$];

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        bund_t z;
        z = '{v: 1'b0, we: 1'b0, rd: 5'd0, data: 64'd0};
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            for (int i = 0; i <= d; i++) mq[d].push_back(z);
        end
    endtask

    task automatic model_edge(input bit s, input bit f, input bit iv,
                              input bit we, input logic [4:0] rd,
                              input logic [63:0] dat);
        bund_t b;
        bund_t t;
        for (int d = 0; d < 3; d++) begin
            if (f) begin
                for (int i = 0; i < mq[d].size(); i++) begin
                    t = mq[d][i];
                    t.v = 1'b0;
                    t.we = 1'b0;
                    mq[d][i] = t;
                end
            end else if (!s) begin
                b = '{v: iv, we: we & iv, rd: rd, data: dat};
                mq[d].push_front(b);
                void'(mq[d].pop_back());
            end
        end
    endtask

    task automatic check_model(input int d);
        bund_t last;
        int cnt;
        bit hit;
        logic [63:0] fd;
        last = mq[d][d];
        cnt = 0;
        hit = 1'b0;
        fd = '0;
        for (int i = 0; i <= d; i++) begin
            if (mq[d][i].v) cnt++;
            if (!hit && mq[d][i].v && mq[d][i].we &&
                mq[d][i].rd == fwd_rd && fwd_rd != 5'd31) begin
                hit = 1'b1;
                fd = mq[d][i].data;
            end
        end
        check($sformatf("d%0d_valid", d + 1), 64'(vo_a[d]), 64'(last.v));
        check($sformatf("d%0d_regwe", d + 1), 64'(we_a[d]),
              64'(last.v & last.we));
        check($sformatf("d%0d_rd", d + 1), 64'(rd_a[d]), 64'(last.rd));
        check($sformatf("d%0d_data", d + 1), dat_a[d], last.data);
        check($sformatf("d%0d_fwd_hit", d + 1), 64'(hit_a[d]), 64'(hit));
        check($sformatf("d%0d_fwd_data", d + 1), fdat_a[d], fd);
        check($sformatf("d%0d_occ", d + 1), 64'(occ_a[d]), 64'(cnt));
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) check_model(d);
    endtask

    task automatic step(input bit s, input bit f, input bit iv,
                        input bit we, input logic [4:0] rd,
                        input logic [63:0] dat);
        stall = s;
        flush = f;
        in_valid = iv;
        RegWE = we;
        Rd = rd;
        DataIn = dat;
        @(posedge clk);
        model_edge(s, f, iv, we, rd, dat);
        #1;
        check_all();
    endtask

    // Reset asserted and checked between edges, well before the next one.
    task automatic pulse_reset();
        #1;
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        reset = 1'b0;
        #1;
    endtask

    typedef struct {
        bit          s;
        bit          f;
        bit          iv;
        logic [4:0]  rd;
        logic [63:0] dat;
        bit          e_vo;
        logic [4:0]  e_rd;
        logic [63:0] e_dat;
        int          e_occ;
    } vec_t;

    vec_t tbl [14];

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        RegWE = 1'b0;
        Rd = '0;
        DataIn = '0;
        fwd_rd = '0;
        model_reset();

        // stall flush iv rd dat | valid rd data occ  (DEPTH=3, RegWE=iv)
        tbl[0]  = '{0, 0, 1, 5'd1, 64'hA,  0, 5'd0, 64'h0, 1};
        tbl[1]  = '{0, 0, 1, 5'd2, 64'hB,  0, 5'd0, 64'h0, 2};
        tbl[2]  = '{0, 0, 1, 5'd3, 64'hC,  1, 5'd1, 64'hA, 3};
        tbl[3]  = '{1, 0, 1, 5'd9, 64'h99, 1, 5'd1, 64'hA, 3};
        tbl[4]  = '{1, 0, 1, 5'd8, 64'h88, 1, 5'd1, 64'hA, 3};
        tbl[5]  = '{0, 0, 1, 5'd4, 64'hD,  1, 5'd2, 64'hB, 3};
        tbl[6]  = '{0, 0, 0, 5'd0, 64'h0,  1, 5'd3, 64'hC, 2};
        tbl[7]  = '{0, 0, 0, 5'd0, 64'h0,  1, 5'd4, 64'hD, 1};
        tbl[8]  = '{0, 0, 0, 5'd0, 64'h0,  0, 5'd0, 64'h0, 0};
        tbl[9]  = '{0, 0, 1, 5'd5, 64'h5,  0, 5'd0, 64'h0, 1};
        tbl[10] = '{0, 0, 1, 5'd6, 64'h6,  0, 5'd0, 64'h0, 2};
        tbl[11] = '{0, 0, 1, 5'd7, 64'h7,  1, 5'd5, 64'h5, 3};
        tbl[12] = '{1, 1, 1, 5'd12, 64'hEE, 0, 5'd5, 64'h5, 0};
        tbl[13] = '{0, 0, 0, 5'd0, 64'h0,  0, 5'd6, 64'h6, 0};

        #3;
        check_all();
        reset = 1'b0;
        #1;

        // DEPTH=1 pass-through
        step(0, 0, 1, 1, 5'd3, 64'd10);
        check("pass_valid", 64'(vo_a[0]), 64'd1);
        check("pass_regwe", 64'(we_a[0]), 64'd1);
        check("pass_rd", 64'(rd_a[0]), 64'd3);
        check("pass_data", dat_a[0], 64'd10);
        check("pass_occ", 64'(occ_a[0]), 64'd1);

        pulse_reset();

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].f, tbl[i].iv, tbl[i].iv,
                 tbl[i].rd, tbl[i].dat);
            check($sformatf("tbl%0d_valid", i), 64'(vo_a[2]),
                  64'(tbl[i].e_vo));
            check($sformatf("tbl%0d_regwe", i), 64'(we_a[2]),
                  64'(tbl[i].e_vo));
            check($sformatf("tbl%0d_rd", i), 64'(rd_a[2]),
                  64'(tbl[i].e_rd));
            check($sformatf("tbl%0d_data", i), dat_a[2], tbl[i].e_dat);
            check($sformatf("tbl%0d_occ", i), 64'(occ_a[2]),
                  64'(tbl[i].e_occ));
            check($sformatf("tbl%0d_hit", i), 64'(hit_a[2]), 64'd0);
        end

        // Forwarding on DEPTH=3
        pulse_reset();
        step(0, 0, 1, 1, 5'd5, 64'h11);
        step(0, 0, 1, 0, 5'd7, 64'h33);
        step(0, 0, 1, 1, 5'd5, 64'h22);
        fwd_rd = 5'd5;
        #1;
        check("fwd5_hit", 64'(hit_a[2]), 64'd1);
        check("fwd5_data", fdat_a[2], 64'h22);
        fwd_rd = 5'd7;
        #1;
        check("fwd_nowe_hit", 64'(hit_a[2]), 64'd0);
        check("fwd_nowe_data", fdat_a[2], 64'd0);
        step(0, 0, 1, 1, 5'd31, 64'h44);
        fwd_rd = 5'd31;
        #1;
        check("fwd_xzr_hit", 64'(hit_a[2]), 64'd0);
        check_all();
        fwd_rd = 5'd5;
        #1;
        check("fwd5b_hit", 64'(hit_a[2]), 64'd1);
        check("fwd5b_data", fdat_a[2], 64'h22);

        // Async reset mid-stream on DEPTH=2
        step(0, 0, 1, 1, 5'd2, 64'h20);
        step(0, 0, 1, 1, 5'd4, 64'h40);
        check("pre_rst_valid", 64'(vo_a[1]), 64'd1);
        pulse_reset();
        check("rst_valid", 64'(vo_a[1]), 64'd0);
        check("rst_data", dat_a[1], 64'd0);
        check("rst_occ", 64'(occ_a[1]), 64'd0);
        step(0, 0, 1, 1, 5'd9, 64'h99);
        check("post_rst_e1_valid", 64'(vo_a[1]), 64'd0);
        step(0, 0, 0, 0, 5'd0, 64'h0);
        check("post_rst_e2_valid", 64'(vo_a[1]), 64'd1);
        check("post_rst_e2_rd", 64'(rd_a[1]), 64'd9);
        check("post_rst_e2_data", dat_a[1], 64'h99);

        // Random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            fwd_rd = 5'($urandom_range(0, 7) == 7 ? 31
                                                  : $urandom_range(0, 5));
            step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 5'($urandom_range(0, 7) == 7 ? 31
                                             : $urandom_range(0, 5)),
                 {32'($urandom), 32'($urandom)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
